// File: rtl/maxpool_pkg.sv
// Shared definitions for the streaming max-pool scheduler: FSM state encoding
// and the counter-width helper used to size frame-geometry ports and counters.
package maxpool_pkg;

    typedef logic [1:0] mp_state_t;

    localparam mp_state_t MP_IDLE  = 2'd0;
    localparam mp_state_t MP_RUN   = 2'd1;
    localparam mp_state_t MP_FLUSH = 2'd2;

    // Bits needed to hold any value in 0..max_v inclusive.
    function automatic int mp_cnt_w(input int max_v);
        return (max_v < 1) ? 1 : $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/max_pool2d.sv
// Combinational KxK window reducer: signed maximum, ties keep the lowest index.
// Window element dy*K+dx occupies bits [(dy*K+dx)*WIDTH +: WIDTH].
module max_pool2d #(
    parameter int K     = 2,
    parameter int WIDTH = 16
) (
    input  logic [K*K*WIDTH-1:0] in_window,
    output logic [WIDTH-1:0]     out_max
);

    logic signed [WIDTH-1:0] best;
    logic signed [WIDTH-1:0] cand;

    always_comb begin
        best = in_window[WIDTH-1:0];
        cand = '0;
        for (int i = 1; i < K * K; i++) begin
            cand = in_window[i*WIDTH +: WIDTH];
            // Strictly greater so an equal later element never displaces an earlier one.
            if (cand > best) begin
                best = cand;
            end
        end
        out_max = best;
    end

endmodule

// File: rtl/maxpool_stream_ctrl.sv
// Streaming KxK / stride-K max-pool scheduler: buffers K-1 rows of the incoming
// raster stream and emits one pooled pixel per complete window over valid/ready.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are both
// high; a source holds valid and data stable until it transfers, and ready may
// depend combinationally on the consumer's own ready (in_ready follows out_ready).
module maxpool_stream_ctrl
    import maxpool_pkg::*;
#(
    parameter int K     = 2,
    parameter int WIDTH = 16,
    parameter int MAX_W = 416,
    parameter int MAX_H = 416
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [mp_cnt_w(MAX_W)-1:0] cfg_width,
    input  logic [mp_cnt_w(MAX_H)-1:0] cfg_height,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 dbg_state_o
);

    localparam int CW = mp_cnt_w(MAX_W);
    localparam int HW = mp_cnt_w(MAX_H);
    localparam int KW = mp_cnt_w(K - 1);

    mp_state_t         state_q, state_d;
    logic [CW-1:0]     width_q, width_d;
    logic [HW-1:0]     height_q, height_d;
    logic [CW-1:0]     wlim_q, wlim_d;
    logic [HW-1:0]     hlim_q, hlim_d;
    logic [CW-1:0]     col_q, col_d;
    logic [HW-1:0]     row_q, row_d;
    logic [KW-1:0]     col_mod_q, col_mod_d;
    logic [KW-1:0]     row_mod_q, row_mod_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;

    logic [WIDTH-1:0]  lb_q [K-1][MAX_W];
    logic [WIDTH-1:0]  sr_q [K-1];

    logic              accept;
    logic              last_col;
    logic              last_row;
    logic              win_fire;
    logic [CW-1:0]     rd_base;
    logic [K*K*WIDTH-1:0] window;
    logic [WIDTH-1:0]  pool_max;

    assign in_ready    = (state_q == MP_RUN) && !(out_valid_q && !out_ready);
    assign accept      = in_valid && in_ready;
    assign last_col    = (col_q == width_q - CW'(1));
    assign last_row    = (row_q == height_q - HW'(1));
    // The limits are the largest multiples of K, so remainder rows/columns never fire.
    assign win_fire    = accept && (row_mod_q == KW'(K - 1)) && (col_mod_q == KW'(K - 1))
                         && (row_q < hlim_q) && (col_q < wlim_q);
    assign rd_base     = col_q - CW'(K - 1);

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign busy        = (state_q != MP_IDLE);
    assign done        = (state_q == MP_FLUSH) && !out_valid_q;
    assign dbg_state_o = state_q;

    always_comb begin
        window = '0;
        for (int dy = 0; dy < K - 1; dy++) begin
            for (int dx = 0; dx < K; dx++) begin
                window[(dy*K+dx)*WIDTH +: WIDTH] = lb_q[dy][rd_base + CW'(dx)];
            end
        end
        for (int dx = 0; dx < K - 1; dx++) begin
            window[((K-1)*K+dx)*WIDTH +: WIDTH] = sr_q[dx];
        end
        window[(K*K-1)*WIDTH +: WIDTH] = in_data;
    end

    max_pool2d #(
        .K     (K),
        .WIDTH (WIDTH)
    ) u_max_pool2d (
        .in_window (window),
        .out_max   (pool_max)
    );

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        wlim_d      = wlim_q;
        hlim_d      = hlim_q;
        col_d       = col_q;
        row_d       = row_q;
        col_mod_d   = col_mod_q;
        row_mod_d   = row_mod_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            MP_IDLE: begin
                if (start) begin
                    state_d   = MP_RUN;
                    width_d   = cfg_width;
                    height_d  = cfg_height;
                    wlim_d    = (cfg_width / CW'(K)) * CW'(K);
                    hlim_d    = (cfg_height / HW'(K)) * HW'(K);
                    col_d     = '0;
                    row_d     = '0;
                    col_mod_d = '0;
                    row_mod_d = '0;
                end
            end
            MP_RUN: begin
                if (accept) begin
                    if (last_col) begin
                        col_d     = '0;
                        col_mod_d = '0;
                        row_d     = row_q + HW'(1);
                        row_mod_d = (row_mod_q == KW'(K - 1)) ? '0 : row_mod_q + KW'(1);
                        if (last_row) begin
                            state_d = MP_FLUSH;
                        end
                    end else begin
                        col_d     = col_q + CW'(1);
                        col_mod_d = (col_mod_q == KW'(K - 1)) ? '0 : col_mod_q + KW'(1);
                    end
                end
            end
            MP_FLUSH: begin
                if (!out_valid_q) begin
                    state_d = MP_IDLE;
                end
            end
            default: state_d = MP_IDLE;
        endcase

        // A new result may replace the one being consumed in the same cycle.
        if (win_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = pool_max;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= MP_IDLE;
            width_q     <= '0;
            height_q    <= '0;
            wlim_q      <= '0;
            hlim_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            col_mod_q   <= '0;
            row_mod_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            wlim_q      <= wlim_d;
            hlim_q      <= hlim_d;
            col_q       <= col_d;
            row_q       <= row_d;
            col_mod_q   <= col_mod_d;
            row_mod_q   <= row_mod_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Pixel storage needs no reset; stale contents are always overwritten before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (row_mod_q != KW'(K - 1)) begin
                lb_q[row_mod_q][col_q] <= in_data;
            end else begin
                for (int i = 0; i < K - 2; i++) begin
                    sr_q[i] <= sr_q[i+1];
                end
                sr_q[K-2] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Directed bench for maxpool_stream_ctrl with K=2: raster frames, signed data,
// remainder handling, output backpressure, mid-frame reset and ignored start.
module tb_maxpool_stream_ctrl;

    localparam int K     = 2;
    localparam int WIDTH = 16;
    localparam int MAX_W = 416;
    localparam int MAX_H = 416;
    localparam int CW    = $clog2(MAX_W + 1);
    localparam int HW    = $clog2(MAX_H + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CW-1:0]    cfg_width;
    logic [HW-1:0]    cfg_height;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    int total;
    int bad;
    int done_cnt;
    int got_at_done;
    int ready_mode;
    int rdy_phase;
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;
    logic [WIDTH-1:0] got_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] pix_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    maxpool_stream_ctrl #(
        .K     (K),
        .WIDTH (WIDTH),
        .MAX_W (MAX_W),
        .MAX_H (MAX_H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Downstream: always ready, or ready one cycle in three.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            out_ready = 1'b1;
        end else begin
            rdy_phase = (rdy_phase + 1) % 3;
            out_ready = (rdy_phase == 0);
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    bad++;
                    $display("FAIL hold: out_valid=%0b out_data=%0d required 1/%0d",
                             out_valid, $signed(out_data), $signed(prev_data));
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_in_ready: in_ready=%0b required 0", in_ready);
                end
            end
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_data  = out_data;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                got_q.push_back(out_data);
            end
            if (done === 1'b1) begin
                done_cnt++;
                got_at_done = got_q.size();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic start_frame(input int w, input int h);
        start      = 1'b1;
        cfg_width  = CW'(w);
        cfg_height = HW'(h);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Sends n_pix pixels of pix_q; start_at injects a start pulse (2x2 config) with that pixel.
    task automatic drive_frame(input int w, input int h, input int n_pix, input int start_at,
                               output int stalls);
        int  waited;
        bit  lat_pend;
        int  r;
        int  c;
        stalls   = 0;
        lat_pend = 1'b0;
        for (int i = 0; i < n_pix; i++) begin
            in_valid = 1'b1;
            in_data  = pix_q[i];
            if (i == start_at) begin
                start      = 1'b1;
                cfg_width  = CW'(2);
                cfg_height = HW'(2);
            end
            waited = 0;
            forever begin
                @(negedge clk);
                if (lat_pend) begin
                    total++;
                    if (out_valid !== 1'b1) begin
                        bad++;
                        $display("FAIL latency pix%0d: out_valid=%0b required 1", i - 1, out_valid);
                    end
                    lat_pend = 1'b0;
                end
                if (in_ready === 1'b1) break;
                waited++;
                if (waited > 60) begin
                    total++;
                    bad++;
                    $display("FAIL in_ready_timeout pix%0d: in_ready=%0b required 1", i, in_ready);
                    break;
                end
            end
            stalls += waited;
            @(posedge clk);
            #1;
            start    = 1'b0;
            r        = i / w;
            c        = i % w;
            lat_pend = (r % K == K - 1) && (c % K == K - 1) && (r < (h / K) * K) && (c < (w / K) * K);
        end
        in_valid = 1'b0;
        @(negedge clk);
        if (lat_pend) begin
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL latency last: out_valid=%0b required 1", out_valid);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: done_cnt=%0d required %0d", done_cnt, d0 + 1);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp(input int n, input int base, input int step);
        pix_q.delete();
        for (int i = 0; i < n; i++) pix_q.push_back(WIDTH'(base + step * i));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total += 6;
        if (in_ready !== 1'b0)  begin bad++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        if (out_data !== '0)    begin bad++; $display("FAIL reset_out_data: got %0d required 0", out_data); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %0b required 0", busy); end
        if (done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %0b required 0", done); end
        if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: in_ready=%0b busy=%0b required 0/0", in_ready, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int stalls;
        int d0;
        ready_mode = 0;
        load_ramp(16, 0, 1);
        exp_q = {16'd5, 16'd7, 16'd13, 16'd15};
        got_q.delete();
        d0 = done_cnt;
        start_frame(4, 4);
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || dbg_state !== 2'd1) begin
            bad++;
            $display("FAIL basic_run: busy=%0b state=%0d required 1/1", busy, dbg_state);
        end
        @(posedge clk);
        #1;
        drive_frame(4, 4, 16, -1, stalls);
        wait_done(d0);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL basic_out%0d: got %0d required %0d", i, (i < got_q.size()) ? $signed(got_q[i]) : -99999, $signed(exp_q[i]));
            end
        end
        total += 4;
        if (done_cnt != d0 + 1)  begin bad++; $display("FAIL basic_done_pulses: got %0d required %0d", done_cnt - d0, 1); end
        if (got_at_done != 4)    begin bad++; $display("FAIL basic_done_order: outputs before done %0d required 4", got_at_done); end
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL basic_idle: busy=%0b state=%0d required 0/0", busy, dbg_state); end
        if (stalls != 0)         begin bad++; $display("FAIL basic_bubbles: stall cycles %0d required 0", stalls); end
    endtask

    task automatic test_negative();
        int stalls;
        int d0;
        ready_mode = 0;
        load_ramp(16, -1, -1);
        exp_q = {16'(-1), 16'(-3), 16'(-9), 16'(-11)};
        got_q.delete();
        d0 = done_cnt;
        start_frame(4, 4);
        drive_frame(4, 4, 16, -1, stalls);
        wait_done(d0);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL neg_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL neg_out%0d: got %0d required %0d", i, (i < got_q.size()) ? $signed(got_q[i]) : -99999, $signed(exp_q[i]));
            end
        end
        total++;
        if (done_cnt != d0 + 1) begin bad++; $display("FAIL neg_done: pulses %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_remainder();
        int stalls;
        int d0;
        ready_mode = 0;
        load_ramp(15, 0, 1);
        exp_q = {16'd6, 16'd8};
        got_q.delete();
        d0 = done_cnt;
        start_frame(5, 3);
        drive_frame(5, 3, 15, -1, stalls);
        wait_done(d0);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rem_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rem_out%0d: got %0d required %0d", i, (i < got_q.size()) ? $signed(got_q[i]) : -99999, $signed(exp_q[i]));
            end
        end
        total += 2;
        if (done_cnt != d0 + 1) begin bad++; $display("FAIL rem_done: pulses %0d required 1", done_cnt - d0); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL rem_idle: busy=%0b required 0", busy); end
    endtask

    task automatic test_backpressure();
        int stalls;
        int d0;
        ready_mode = 1;
        rdy_phase  = 0;
        load_ramp(16, 0, 1);
        exp_q = {16'd5, 16'd7, 16'd13, 16'd15};
        got_q.delete();
        d0 = done_cnt;
        start_frame(4, 4);
        drive_frame(4, 4, 16, -1, stalls);
        wait_done(d0);
        ready_mode = 0;
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bp_out%0d: got %0d required %0d", i, (i < got_q.size()) ? $signed(got_q[i]) : -99999, $signed(exp_q[i]));
            end
        end
        total += 3;
        if (done_cnt != d0 + 1) begin bad++; $display("FAIL bp_done: pulses %0d required 1", done_cnt - d0); end
        if (got_at_done != 4)   begin bad++; $display("FAIL bp_done_order: outputs before done %0d required 4", got_at_done); end
        if (stalls == 0)        begin bad++; $display("FAIL bp_stalls: stall cycles %0d required >0", stalls); end
    endtask

    task automatic test_reset_mid();
        int stalls;
        int d0;
        ready_mode = 0;
        load_ramp(16, 100, 1);
        start_frame(4, 4);
        drive_frame(4, 4, 6, -1, stalls);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total += 3;
        if (busy !== 1'b0)      begin bad++; $display("FAIL midrst_busy: got %0b required 0", busy); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %0b required 0", out_valid); end
        if (in_ready !== 1'b0)  begin bad++; $display("FAIL midrst_in_ready: got %0b required 0", in_ready); end
        @(posedge clk);
        #1;
        load_ramp(16, 0, 1);
        exp_q = {16'd5, 16'd7, 16'd13, 16'd15};
        got_q.delete();
        d0 = done_cnt;
        start_frame(4, 4);
        drive_frame(4, 4, 16, -1, stalls);
        wait_done(d0);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL midrst_out%0d: got %0d required %0d", i, (i < got_q.size()) ? $signed(got_q[i]) : -99999, $signed(exp_q[i]));
            end
        end
        total++;
        if (done_cnt != d0 + 1) begin bad++; $display("FAIL midrst_done: pulses %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_start_ignored();
        int stalls;
        int d0;
        ready_mode = 0;
        load_ramp(16, 0, 1);
        exp_q = {16'd5, 16'd7, 16'd13, 16'd15};
        got_q.delete();
        d0 = done_cnt;
        start_frame(4, 4);
        drive_frame(4, 4, 16, 3, stalls);
        wait_done(d0);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL startign_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL startign_out%0d: got %0d required %0d", i, (i < got_q.size()) ? $signed(got_q[i]) : -99999, $signed(exp_q[i]));
            end
        end
        total += 2;
        if (done_cnt != d0 + 1) begin bad++; $display("FAIL startign_done: pulses %0d required 1", done_cnt - d0); end
        if (got_at_done != 4)   begin bad++; $display("FAIL startign_done_order: outputs before done %0d required 4", got_at_done); end
    endtask

    task automatic test_tiny();
        int stalls;
        int d0;
        ready_mode = 0;
        load_ramp(4, 50, 1);
        got_q.delete();
        d0 = done_cnt;
        start_frame(1, 4);
        drive_frame(1, 4, 4, -1, stalls);
        wait_done(d0);
        total += 3;
        if (got_q.size() != 0)  begin bad++; $display("FAIL tiny_count: got %0d required 0", got_q.size()); end
        if (done_cnt != d0 + 1) begin bad++; $display("FAIL tiny_done: pulses %0d required 1", done_cnt - d0); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL tiny_idle: busy=%0b required 0", busy); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total       = 0;
        bad         = 0;
        done_cnt    = 0;
        got_at_done = 0;
        ready_mode  = 0;
        rdy_phase   = 0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        out_ready   = 1'b1;
        rst_n       = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        cfg_width   = '0;
        cfg_height  = '0;
        test_reset();
        test_basic();
        test_negative();
        test_remainder();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        test_tiny();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
